// File: rtl/wb_arbiter_rr2.sv
// wb_arbiter_rr2: round-robin arbiter sharing one Wishbone slave between two
// masters (SoC bus and a DMA/USB-side engine). The grant is registered; the
// address/data/ack paths are combinational through the granted master.
// Optional slave-hang timeout: define WB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module wb_arbiter_rr2 #(
   parameter int unsigned AW        = 16,
   parameter int unsigned DW        = 32,
   parameter int unsigned MW        = DW / 8,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] m0_wb_addr,
   input  logic [DW-1:0] m0_wb_wdata,
   input  logic [MW-1:0] m0_wb_wmsk,
   input  logic          m0_wb_we,
   input  logic          m0_wb_cyc,
   output logic [DW-1:0] m0_wb_rdata,
   output logic          m0_wb_ack,
   input  logic [AW-1:0] m1_wb_addr,
   input  logic [DW-1:0] m1_wb_wdata,
   input  logic [MW-1:0] m1_wb_wmsk,
   input  logic          m1_wb_we,
   input  logic          m1_wb_cyc,
   output logic [DW-1:0] m1_wb_rdata,
   output logic          m1_wb_ack,
   output logic [AW-1:0] s_wb_addr,
   output logic [DW-1:0] s_wb_wdata,
   output logic [MW-1:0] s_wb_wmsk,
   output logic          s_wb_we,
   output logic          s_wb_cyc,
   input  logic [DW-1:0] s_wb_rdata,
   input  logic          s_wb_ack,
   output logic          timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          sel_c;
   logic          req_c;
   logic          ack_c;
   logic [DW-1:0] rdata_c;

   // Timeout counter must have at least one bit.
   if (TIMEOUT_W < 1) begin : g_bad_timeout_w
      $error("wb_arbiter_rr2: TIMEOUT_W must be >= 1");
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo_cnt_q;
   logic                 tmo_hit_c;
   logic                 tmo_set_c;
   logic                 timeout_err_q;

   assign tmo_hit_c   = (tmo_cnt_q == {TIMEOUT_W{1'b1}});
   assign timeout_err = timeout_err_q;

   // Cycles spent in the current grant; zero while idle so each grant starts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
      end
   end

   // Sticky hung-slave flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_err_q <= 1'b0;
      end else if (tmo_set_c) begin
         timeout_err_q <= 1'b1;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   // Grant state and round-robin history (last=1 lets m0 win the first tie).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Arbitration, slave-side mux and ack/rdata return path.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      sel_c       = 1'b0;
      req_c       = 1'b0;
      ack_c       = 1'b0;
      rdata_c     = '0;
      s_wb_addr   = '0;
      s_wb_wdata  = '0;
      s_wb_wmsk   = '0;
      s_wb_we     = 1'b0;
      s_wb_cyc    = 1'b0;
      m0_wb_ack   = 1'b0;
      m0_wb_rdata = '0;
      m1_wb_ack   = 1'b0;
      m1_wb_rdata = '0;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_set_c   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (m0_wb_cyc && m1_wb_cyc) begin
               state_d = last_q ? ST_GRANT0 : ST_GRANT1;
            end else if (m0_wb_cyc) begin
               state_d = ST_GRANT0;
            end else if (m1_wb_cyc) begin
               state_d = ST_GRANT1;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            sel_c      = (state_q == ST_GRANT1);
            req_c      = sel_c ? m1_wb_cyc   : m0_wb_cyc;
            s_wb_addr  = sel_c ? m1_wb_addr  : m0_wb_addr;
            s_wb_wdata = sel_c ? m1_wb_wdata : m0_wb_wdata;
            s_wb_wmsk  = sel_c ? m1_wb_wmsk  : m0_wb_wmsk;
            s_wb_we    = sel_c ? m1_wb_we    : m0_wb_we;
            s_wb_cyc   = req_c;
            if (s_wb_ack) begin
               ack_c   = 1'b1;
               rdata_c = s_wb_rdata;
               state_d = ST_IDLE;
               last_d  = sel_c;
            end else if (!req_c) begin
               state_d = ST_IDLE;
               last_d  = sel_c;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (tmo_hit_c) begin
               ack_c     = 1'b1;
               rdata_c   = '1;
               s_wb_cyc  = 1'b0;
               state_d   = ST_IDLE;
               last_d    = sel_c;
               tmo_set_c = 1'b1;
            end
`endif
            m0_wb_ack   = ack_c & ~sel_c;
            m1_wb_ack   = ack_c & sel_c;
            m0_wb_rdata = sel_c ? '0 : rdata_c;
            m1_wb_rdata = sel_c ? rdata_c : '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
